// File: rtl/conv_encoder_pkg.sv
// rtl/conv_encoder_pkg.sv - shared constants, rate encodings and puncture helpers for the convolutional encoder
package conv_encoder_pkg;

    localparam int K = 7;

    // Tap vectors ordered {x, d1, d2, d3, d4, d5, d6}, MSB is the current input bit
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_e;

    // The reserved code encodes as plain rate 1/2
    function automatic rate_e norm_rate(input logic [1:0] r);
        rate_e rr;
        rr = rate_e'(r);
        return (rr == RATE_RSVD) ? RATE_1_2 : rr;
    endfunction

    // Which of {A, B} survive puncturing at the given phase
    function automatic logic [1:0] keep_mask(input rate_e r, input logic [1:0] ph);
        logic [1:0] m;
        case (r)
            RATE_2_3: m = (ph == 2'd0) ? 2'b11 : 2'b10;
            RATE_3_4: begin
                case (ph)
                    2'd0:    m = 2'b11;
                    2'd1:    m = 2'b10;
                    default: m = 2'b01;
                endcase
            end
            default:  m = 2'b11;
        endcase
        return m;
    endfunction

    // Phase after one accepted input bit
    function automatic logic [1:0] next_phase(input rate_e r, input logic [1:0] ph);
        logic [1:0] n;
        case (r)
            RATE_2_3: n = (ph == 2'd0) ? 2'd1 : 2'd0;
            RATE_3_4: n = (ph == 2'd2) ? 2'd0 : 2'(ph + 2'd1);
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/conv_encoder_core.sv
// rtl/conv_encoder_core.sv - K=7 delay line and generator tap logic with shift enable and sync clear
module conv_encoder_core
    import conv_encoder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic a,
    output logic b
);

    // d_q[0] is d1 (previous input), d_q[K-2] is d6 (oldest)
    logic [K-2:0] d_q;
    logic [K-2:0] d_d;
    logic [K-2:0] d_eff;
    logic [K-1:0] taps;

    // Clear applies to the same-cycle encode, so outputs see an all-zero history on a start
    always_comb begin
        d_eff     = clr ? '0 : d_q;
        taps      = '0;
        taps[K-1] = x;
        for (int i = 0; i < K - 1; i++) begin
            taps[K-2-i] = d_eff[i];
        end
        a   = ^(taps & G0);
        b   = ^(taps & G1);
        d_d = en ? {d_eff[K-3:0], x} : d_eff;
    end

    // Delay line register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate 1/2 K=7 convolutional encoder with 2/3 and 3/4 puncturing and serial output
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int RATE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RATE_W-1:0] rate,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_rdy,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_rdy
);

    logic [1:0] cnt_q, cnt_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] phase_q, phase_d;
    rate_e      rate_q, rate_d;
    logic       rdy_q, rdy_d;

    logic       idle;
    logic       start_eff;
    rate_e      rate_eff;
    logic [1:0] phase_eff;
    logic [1:0] keep;
    logic       accept;
    logic       pop;
    logic       code_a;
    logic       code_b;

    // pend_q[1] is the older bit and is always the one presented
    assign out_valid = (cnt_q != 2'd0);
    assign out_bit   = pend_q[1];

    // Handshake control; a start seen while idle overrides rate and phase in the same cycle
    always_comb begin
        idle      = (cnt_q == 2'd0);
        start_eff = start & idle;
        rate_eff  = start_eff ? norm_rate(rate[1:0]) : rate_q;
        phase_eff = start_eff ? 2'd0 : phase_q;
        keep      = keep_mask(rate_eff, phase_eff);
        in_rdy    = rdy_q & (idle | ((cnt_q == 2'd1) & out_rdy));
        accept    = in_valid & in_rdy;
        pop       = out_valid & out_rdy;
    end

    conv_encoder_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (start_eff),
        .en    (accept),
        .x     (in_bit),
        .a     (code_a),
        .b     (code_b)
    );

    // Output buffer drain/reload and puncture phase advance
    always_comb begin
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        phase_d = phase_eff;
        rate_d  = rate_eff;
        rdy_d   = 1'b1;
        if (pop) begin
            if (cnt_q == 2'd2) begin
                pend_d = {pend_q[0], 1'b0};
                cnt_d  = 2'd1;
            end else begin
                cnt_d  = 2'd0;
            end
        end
        // An accept only happens once the buffer is empty after this cycle's pop, so it overwrites
        if (accept) begin
            phase_d = next_phase(rate_eff, phase_eff);
            case (keep)
                2'b11: begin
                    pend_d = {code_a, code_b};
                    cnt_d  = 2'd2;
                end
                2'b10: begin
                    pend_d = {code_a, 1'b0};
                    cnt_d  = 2'd1;
                end
                2'b01: begin
                    pend_d = {code_b, 1'b0};
                    cnt_d  = 2'd1;
                end
                default: begin
                    cnt_d = cnt_d;
                end
            endcase
        end
    end

    // Control state registers; rdy_q holds in_rdy low until the first clock after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            pend_q  <= 2'b00;
            phase_q <= 2'd0;
            rate_q  <= RATE_1_2;
            rdy_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            phase_q <= phase_d;
            rate_q  <= rate_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder against a polynomial reference model
module tb_conv_encoder;

    localparam logic [6:0] G0_TB = 7'o133;
    localparam logic [6:0] G1_TB = 7'o171;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] rate;
    logic       in_bit;
    logic       in_valid;
    logic       in_rdy;
    logic       out_bit;
    logic       out_valid;
    logic       out_rdy;

    int checks   = 0;
    int failures = 0;

    bit frame[$];
    bit got[$];
    bit exp_q[$];
    bit rdy_trace[$];
    int n_acc = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    conv_encoder #(.RATE_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rate      (rate),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_rdy    (in_rdy),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_rdy   (out_rdy)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_rdy) got.push_back(out_bit);
            if (in_valid && in_rdy) n_acc++;
        end
    end

    // Reference: each coded bit is the parity of generator-weighted input history, then a keep pattern
    function automatic void build_expected(input int r);
        int p;
        bit ka[3];
        bit kb[3];
        bit a;
        bit b;
        exp_q.delete();
        case (r)
            1: begin p = 2; ka = '{1'b1, 1'b1, 1'b0}; kb = '{1'b1, 1'b0, 1'b0}; end
            2: begin p = 3; ka = '{1'b1, 1'b1, 1'b0}; kb = '{1'b1, 1'b0, 1'b1}; end
            default: begin p = 1; ka = '{1'b1, 1'b0, 1'b0}; kb = '{1'b1, 1'b0, 1'b0}; end
        endcase
        for (int n = 0; n < frame.size(); n++) begin
            a = 1'b0;
            b = 1'b0;
            for (int j = 0; j < 7; j++) begin
                if (n - j >= 0) begin
                    a = a ^ (G0_TB[6-j] & frame[n-j]);
                    b = b ^ (G1_TB[6-j] & frame[n-j]);
                end
            end
            if (ka[n % p]) exp_q.push_back(a);
            if (kb[n % p]) exp_q.push_back(b);
        end
    endfunction

    task automatic drive_bits(input int from, input bit do_start, input logic [1:0] r, input bit rand_rdy);
        int  idx;
        int  cyc;
        int  budget;
        bit  acc;
        idx    = from;
        cyc    = 0;
        budget = 20 * (frame.size() - from) + 50;
        rdy_trace.delete();
        while (idx < frame.size() && cyc < budget) begin
            start    = do_start && (cyc == 0);
            rate     = r;
            in_valid = 1'b1;
            in_bit   = frame[idx];
            out_rdy  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_rdy;
            rdy_trace.push_back(in_rdy);
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (idx != frame.size()) begin
            failures++;
            $display("FAIL drive_timeout: accepted %0d required %0d", idx, frame.size());
        end
    endtask

    task automatic drain();
        bit done;
        done     = 1'b0;
        in_valid = 1'b0;
        out_rdy  = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: out_valid still %0d required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rate     = 2'b00;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        out_rdy  = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %0b required 0", in_rdy); end
        checks++;
        if (out_bit !== 1'b0) begin failures++; $display("FAIL reset_out_bit: got %0b required 0", out_bit); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin failures++; $display("FAIL post_reset_in_rdy: got %0b required 1", in_rdy); end
    endtask

    task automatic test_impulse();
        bit imp[20];
        int base;
        imp = '{1,1, 0,1, 1,1, 1,1, 0,0, 1,0, 1,1, 0,0, 0,0, 0,0};
        frame.delete();
        frame.push_back(1'b1);
        repeat (9) frame.push_back(1'b0);
        base   = got.size();
        mon_en = 1'b1;
        drive_bits(0, 1'b1, 2'b00, 1'b0);
        drain();
        checks++;
        if (got.size() - base != 20) begin
            failures++;
            $display("FAIL impulse_len: got %0d required 20", got.size() - base);
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got[base+i] !== imp[i]) begin
                    failures++;
                    $display("FAIL impulse_bit[%0d]: got %0b required %0b", i, got[base+i], imp[i]);
                end
            end
        end
        for (int i = 0; i < rdy_trace.size(); i++) begin
            checks++;
            if (rdy_trace[i] !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL impulse_in_rdy[%0d]: got %0b required %0b", i, rdy_trace[i], (i % 2) == 0);
            end
        end
    endtask

    task automatic test_directed(input logic [1:0] r, input int nin);
        int base;
        frame.delete();
        frame.push_back(1'b1);
        repeat (nin - 1) frame.push_back(1'b0);
        base   = got.size();
        mon_en = 1'b1;
        drive_bits(0, 1'b1, r, 1'b0);
        drain();
        build_expected(int'(r));
        checks++;
        if (got.size() - base != exp_q.size()) begin
            failures++;
            $display("FAIL directed_len rate=%0d: got %0d required %0d", r, got.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL directed_bit rate=%0d [%0d]: got %0b required %0b", r, i, got[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random(input logic [1:0] r, input int nin, input int want_len);
        int base;
        int bad;
        frame.delete();
        for (int i = 0; i < nin; i++) frame.push_back(1'($urandom_range(0, 1)));
        base   = got.size();
        mon_en = 1'b1;
        drive_bits(0, 1'b1, r, 1'b1);
        drain();
        build_expected(int'(r));
        checks++;
        if (got.size() - base != want_len) begin
            failures++;
            $display("FAIL random_len rate=%0d: got %0d required %0d", r, got.size() - base, want_len);
        end else begin
            bad = 0;
            for (int i = 0; i < want_len; i++) if (got[base+i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_bits rate=%0d: mismatched %0d required 0", r, bad);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int bad;
        frame.delete();
        frame = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        base     = got.size();
        n_acc    = n_acc;
        mon_en   = 1'b1;
        start    = 1'b1;
        rate     = 2'b00;
        in_valid = 1'b1;
        in_bit   = frame[0];
        out_rdy  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        in_bit  = frame[1];
        out_rdy = 1'b0;
        begin
            int acc0;
            acc0 = n_acc;
            repeat (5) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_bit !== 1'b1 || in_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b bit=%0b in_rdy=%0b required 1 1 0", out_valid, out_bit, in_rdy);
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (n_acc != acc0) begin
                failures++;
                $display("FAIL stall_consumed: accepts %0d required %0d", n_acc, acc0);
            end
        end
        out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL release_in_rdy_a: got %0b required 0", in_rdy); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL release_b: valid=%0b bit=%0b in_rdy=%0b required 1 1 1", out_valid, out_bit, in_rdy);
        end
        @(posedge clk);
        #1;
        drive_bits(2, 1'b0, 2'b00, 1'b1);
        drain();
        build_expected(0);
        bad = 0;
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) if (got[base+i] !== exp_q[i]) bad++;
        checks++;
        if (got.size() - base != exp_q.size() || bad != 0) begin
            failures++;
            $display("FAIL backpressure_stream: len %0d mismatched %0d required len %0d mismatched 0",
                     got.size() - base, bad, exp_q.size());
        end
    endtask

    task automatic test_start_ignored();
        int base;
        int bad;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(1'($urandom_range(0, 1)));
        frame[0] = 1'b1;
        base     = got.size();
        mon_en   = 1'b1;
        drive_bits(0, 1'b1, 2'b10, 1'b0);
        out_rdy  = 1'b0;
        start    = 1'b1;
        rate     = 2'b00;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy_state: valid=%0b in_rdy=%0b required 1 0", out_valid, in_rdy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) frame.push_back(1'($urandom_range(0, 1)));
        drive_bits(6, 1'b0, 2'b00, 1'b1);
        drain();
        build_expected(2);
        bad = 0;
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) if (got[base+i] !== exp_q[i]) bad++;
        checks++;
        if (got.size() - base != 16 || bad != 0) begin
            failures++;
            $display("FAIL start_ignored_stream: len %0d mismatched %0d required len 16 mismatched 0",
                     got.size() - base, bad);
        end
    endtask

    task automatic test_reset_midframe();
        mon_en   = 1'b0;
        start    = 1'b1;
        rate     = 2'b00;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        out_rdy  = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midframe_pre: valid %0b required 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_rdy !== 1'b0 || out_bit !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: valid=%0b in_rdy=%0b bit=%0b required 0 0 0", out_valid, in_rdy, out_bit);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        test_impulse();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_directed(2'b10, 6);
        test_directed(2'b01, 4);
        test_random(2'b01, 1000, 1500);
        test_random(2'b10, 300, 400);
        test_random(2'b00, 100, 200);
        test_random(2'b11, 100, 200);
        test_backpressure();
        test_start_ignored();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
